// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: reset/trap vectors, prioritised redirects,
// halt/resume control and an accepted-fetch counter. Optional macro: PC_GEN_RVC_EN.
module pc_gen #(
  parameter int unsigned           ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]     RESET_ADDR = '0,
  parameter logic [ADDR_W-1:0]     TRAP_ADDR  = 'h100,
  parameter int unsigned           CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              halt_i,
  input  logic              resume_i,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              trap_en_i,
  input  logic              fetch_ready_i,
`ifdef PC_GEN_RVC_EN
  input  logic              inc2_i,
`endif
  output logic [ADDR_W-1:0] pc_o,
  output logic              pc_valid_o,
  output logic              redirect_o,
  output logic              misalign_o,
  output logic [CNT_W-1:0]  fetch_cnt_o
);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALT
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                redirect_q, redirect_d;
  logic                misalign_q, misalign_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                valid;
  logic                accept;
  logic                bad_target;
  logic [ADDR_W-1:0]   inc_amt;

  assign valid  = (state_q == ST_RUN);
  assign accept = valid && fetch_ready_i;

`ifdef PC_GEN_RVC_EN
  assign bad_target = jump_addr_i[0];
  assign inc_amt    = inc2_i ? ADDR_W'(2) : ADDR_W'(4);
`else
  assign bad_target = |jump_addr_i[1:0];
  assign inc_amt    = ADDR_W'(4);
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = 1'b0;
    misalign_d = 1'b0;
    cnt_d      = cnt_q + CNT_W'(accept);

    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN, ST_HALT: begin
        // Redirects win in both RUN and HALT; only the fallback differs per state.
        if (trap_en_i) begin
          pc_d       = TRAP_ADDR;
          redirect_d = 1'b1;
          state_d    = ST_RUN;
        end else if (jump_en_i) begin
          pc_d       = bad_target ? TRAP_ADDR : jump_addr_i;
          redirect_d = 1'b1;
          misalign_d = bad_target;
          state_d    = ST_RUN;
        end else if (state_q == ST_HALT) begin
          if (resume_i) state_d = ST_RUN;
        end else if (halt_i) begin
          state_d = ST_HALT;
        end else if (!stall_i && fetch_ready_i) begin
          pc_d = pc_q + inc_amt;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_ADDR;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc_o        = pc_q;
  assign pc_valid_o  = valid;
  assign redirect_o  = redirect_q;
  assign misalign_o  = misalign_q;
  assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Randomised bench for pc_gen with an in-bench behavioural model compared every cycle,
// plus directed literal checks that pin the model.
module tb_pc_gen;
  localparam logic [31:0] RST_A  = 32'h0000_1000;
  localparam logic [31:0] TRAP_A = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst, stall_i, halt_i, resume_i, jump_en_i, trap_en_i, fetch_ready_i;
  logic [31:0] jump_addr_i;
  logic        inc2_i;
  logic [31:0] pc_o;
  logic        pc_valid_o, redirect_o, misalign_o;
  logic [15:0] fetch_cnt_o;

  pc_gen #(.ADDR_W(32), .RESET_ADDR(RST_A), .TRAP_ADDR(TRAP_A), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .halt_i(halt_i), .resume_i(resume_i),
    .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i), .trap_en_i(trap_en_i),
    .fetch_ready_i(fetch_ready_i),
`ifdef PC_GEN_RVC_EN
    .inc2_i(inc2_i),
`endif
    .pc_o(pc_o), .pc_valid_o(pc_valid_o), .redirect_o(redirect_o),
    .misalign_o(misalign_o), .fetch_cnt_o(fetch_cnt_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0=boot bubble, 1=fetching, 2=halted
  int          m_mode;
  logic [31:0] m_pc;
  logic        m_redir, m_mis;
  int unsigned m_cnt;
  bit          m_known = 1'b0;

  always @(posedge clk) begin
    bit accepted, odd;
    if (!rst) begin
      m_mode = 0; m_pc = RST_A; m_redir = 0; m_mis = 0; m_cnt = 0; m_known = 1'b1;
    end else if (m_known) begin
      accepted = (m_mode == 1) && fetch_ready_i;
`ifdef PC_GEN_RVC_EN
      odd = jump_addr_i[0];
`else
      odd = (jump_addr_i % 4) != 0;
`endif
      m_redir = 0; m_mis = 0;
      if (m_mode == 0) m_mode = 1;
      else if (trap_en_i || jump_en_i) begin
        m_redir = 1;
        m_mode  = 1;
        if (trap_en_i || odd) begin
          m_pc  = TRAP_A;
          m_mis = !trap_en_i;
        end else m_pc = jump_addr_i;
      end else if (m_mode == 2) begin
        if (resume_i) m_mode = 1;
      end else if (halt_i) m_mode = 2;
      else if (!stall_i && fetch_ready_i) begin
`ifdef PC_GEN_RVC_EN
        m_pc = 32'((64'(m_pc) + (inc2_i ? 2 : 4)) % 64'h1_0000_0000);
`else
        m_pc = 32'((64'(m_pc) + 4) % 64'h1_0000_0000);
`endif
      end
      if (accepted) m_cnt = (m_cnt + 1) % 65536;
    end
  end

  always @(negedge clk) begin
    if (m_known)
      chk("cycle", {13'd0, pc_o, pc_valid_o, redirect_o, misalign_o, fetch_cnt_o},
          {13'd0, m_pc, (m_mode == 1), m_redir, m_mis, 16'(m_cnt)});
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    stall_i = 0; halt_i = 0; resume_i = 0; jump_en_i = 0; trap_en_i = 0;
    fetch_ready_i = 0; jump_addr_i = '0; inc2_i = 0;
  endtask

  task automatic jump_to(input logic [31:0] a);
    idle(); jump_en_i = 1; jump_addr_i = a; tick(); idle();
  endtask

  initial begin
    int guard;
    rst = 0; idle();
    tick(); tick();
    chk("rst_valid", 64'(pc_valid_o), 64'd0);
    chk("rst_pc", 64'(pc_o), 64'h1000);
    chk("rst_cnt", 64'(fetch_cnt_o), 64'd0);
    chk("rst_redir", 64'(redirect_o), 64'd0);

    rst = 1; fetch_ready_i = 1;
    tick(); chk("boot_run_pc", 64'({pc_valid_o, pc_o}), 64'h1_0000_1000);
    tick(); chk("run_pc1", 64'(pc_o), 64'h1004);
    tick(); chk("run_pc2", 64'(pc_o), 64'h1008);
    tick(); chk("run_cnt3", 64'(fetch_cnt_o), 64'd3);

    // backpressure then stall with ready
    fetch_ready_i = 0; tick(); tick(); tick();
    chk("bp_pc", 64'(pc_o), 64'h100C);
    chk("bp_cnt", 64'(fetch_cnt_o), 64'd3);
    stall_i = 1; fetch_ready_i = 1; tick(); tick();
    chk("stall_pc", 64'(pc_o), 64'h100C);
    chk("stall_cnt", 64'(fetch_cnt_o), 64'd5);

    jump_to(32'h2000);
    chk("jump_pc", 64'(pc_o), 64'h2000);
    trap_en_i = 1; jump_en_i = 1; jump_addr_i = 32'h3000; stall_i = 1; tick(); idle();
    chk("prio_pc", 64'(pc_o), 64'h100);
    chk("prio_redir", 64'(redirect_o), 64'd1);
    tick(); chk("prio_pulse_end", 64'(redirect_o), 64'd0);

    jump_to(32'h3002);
`ifdef PC_GEN_RVC_EN
    chk("mis_pc", 64'({pc_o, misalign_o}), {31'd0, 32'h3002, 1'b0});
`else
    chk("mis_pc", 64'({pc_o, misalign_o}), {31'd0, 32'h100, 1'b1});
`endif
    tick(); chk("mis_pulse_end", 64'(misalign_o), 64'd0);

    jump_to(32'h40);
    halt_i = 1; tick(); idle();
    chk("halt", 64'({pc_valid_o, pc_o}), 64'h0_0000_0040);
    fetch_ready_i = 1; stall_i = 1; tick();
    chk("halt_ign", 64'({pc_valid_o, pc_o}), 64'h0_0000_0040);
    idle(); resume_i = 1; tick(); idle();
    chk("resume", 64'({pc_valid_o, pc_o}), 64'h1_0000_0040);
    halt_i = 1; tick(); idle();
    jump_to(32'h80);
    chk("halt_jump", 64'({pc_valid_o, pc_o, redirect_o}), {30'd0, 1'b1, 32'h80, 1'b1});
    halt_i = 1; tick();
    resume_i = 1; tick(); idle();
    chk("halt_resume_both", 64'({pc_valid_o, pc_o}), 64'h1_0000_0080);

    jump_to(32'hFFFF_FFFC);
    fetch_ready_i = 1; tick(); idle();
    chk("pc_wrap", 64'(pc_o), 64'd0);

    jump_en_i = 1; jump_addr_i = 32'h500; rst = 0; tick(); idle(); rst = 1;
    chk("rst_mid", 64'({pc_valid_o, redirect_o, pc_o}), {30'd0, 2'b00, 32'h1000});
    tick();

    for (int unsigned i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 99) != 0);
      trap_en_i     = ($urandom_range(0, 19) == 0);
      jump_en_i     = ($urandom_range(0, 7) == 0);
      halt_i        = ($urandom_range(0, 15) == 0);
      resume_i      = ($urandom_range(0, 3) == 0);
      stall_i       = ($urandom_range(0, 4) == 0);
      fetch_ready_i = ($urandom_range(0, 3) != 0);
      inc2_i        = $urandom_range(0, 1) != 0;
      jump_addr_i   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : $urandom;
      tick();
    end

    // fill the counter to its wrap point
    idle(); rst = 1; resume_i = 1; tick(); idle(); fetch_ready_i = 1;
    guard = 0;
    while (m_cnt != 65535 && guard < 70000) begin
      tick(); guard++;
    end
    chk("cnt_fill_bound", 64'(guard < 70000), 64'd1);
    chk("cnt_max", 64'(fetch_cnt_o), 64'hFFFF);
    tick();
    chk("cnt_wrap", 64'(fetch_cnt_o), 64'd0);
    idle(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
